// File: rtl/psum_writeback.sv
// Systolic-array writeback: snapshots the psum matrix on start, requantizes each row to
// unsigned bytes (round-half-up shift, saturate) and writes one row per SRAM access.
module psum_writeback #(
  parameter int unsigned N = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N-1:0][N-1:0][19:0]   in_psum,
  input  logic [4:0]                  shift_param,
  input  logic [12:0]                 base_addr,
  input  logic                        mem_gnt,
  output logic [12:0]                 waddr,
  output logic [N-1:0][7:0]           wdata,
  output logic                        wen_n,
  output logic                        clr_req,
  output logic                        busy,
  output logic                        done,
  output logic                        sat_flag
);

  localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StFin} state_e;

  state_e                      state_q;
  logic [N-1:0][N-1:0][19:0]   snap_q;
  logic [4:0]                  shift_q;
  logic [12:0]                 base_q;
  logic [RowW-1:0]             row_q;

  logic [4:0]                  s_eff;
  logic [20:0]                 q;
  logic [N-1:0][7:0]           qrow;
  logic                        row_sat;

  // Requantize the current row; 21-bit sum keeps the rounding add from overflowing.
  always_comb begin
    s_eff   = (shift_q > 5'd19) ? 5'd19 : shift_q;
    qrow    = '0;
    row_sat = 1'b0;
    q       = '0;
    for (int c = 0; c < int'(N); c++) begin
      q = {1'b0, snap_q[row_q][c]};
      if (s_eff != 5'd0) begin
        q = (q + (21'd1 << (s_eff - 5'd1))) >> s_eff;
      end
      if (q > 21'd255) begin
        qrow[c] = 8'hff;
        row_sat = 1'b1;
      end else begin
        qrow[c] = q[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      row_q    <= '0;
      wen_n    <= 1'b1;
      waddr    <= '0;
      wdata    <= '0;
      clr_req  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      clr_req <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            snap_q   <= in_psum;
            shift_q  <= shift_param;
            base_q   <= base_addr;
            row_q    <= '0;
            sat_flag <= 1'b0;
            clr_req  <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          wdata    <= qrow;
          sat_flag <= sat_flag | row_sat;
          waddr    <= base_q + 13'(row_q);
          wen_n    <= 1'b0;
          state_q  <= StWrite;
        end
        StWrite: begin
          // Everything holds while the grant is withheld.
          if (mem_gnt) begin
            wen_n <= 1'b1;
            if (row_q == RowW'(N - 1)) begin
              done    <= 1'b1;
              state_q <= StFin;
            end else begin
              row_q   <= row_q + RowW'(1);
              state_q <= StLoad;
            end
          end
        end
        StFin: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/psum_writeback.md
Name: psum_writeback

Overview:
- Downstream stage of the NxN systolic array.
- On the array's done pulse it snapshots the N×N 20-bit partial-sum matrix and requantizes each element to 8-bit unsigned (round-half-up right shift plus saturation).
- Writes the result to the output SRAM one row (N bytes) per access, using the active-low write-enable / 13-bit address convention of the array's memory ports.
- Requests a psum clear from the array once the snapshot is taken.

Parameters:
- N, 8, array dimension; rows per run and bytes per row.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  capture request; tie to the array's done pulse.
- in_psum  in  N×N×20, packed [N-1:0][N-1:0][19:0]  array psum matrix; element [r][c].
- shift_param  in  5  right-shift amount; latched at start.
- base_addr  in  13  SRAM row address of row 0; latched at start.
- mem_gnt  in  1  SRAM write grant; a write completes on a clk edge where wen_n=0 and mem_gnt=1.
- waddr  out  13  write address.
- wdata  out  N×8, packed [N-1:0][7:0]  byte c = quantized element [row][c].
- wen_n  out  1  write enable, active low.
- clr_req  out  1  one-cycle pulse to the array's clear input.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- sat_flag  out  1  sticky: some element of the current run saturated.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, row=0, wen_n=1, waddr=0, wdata=0, clr_req=0, done=0, busy=0, sat_flag=0. rst has priority over every other input.
- States: IDLE, LOAD, WRITE, FIN.
- IDLE:
  - On an edge with start=1: snapshot in_psum into an internal N×N×20 register; latch shift_param and base_addr; row=0; sat_flag=0; clr_req=1 for the next cycle only; go to LOAD.
  - The array may be cleared after this edge; the snapshot is independent of it.
- LOAD (1 cycle): compute quantized row `row` from the snapshot and register it into wdata; go to WRITE.
- WRITE:
  - Drive wen_n=0 and waddr = base_addr_q + row, modulo 2^13 (wraps 8191 -> 0).
  - While mem_gnt=0: hold wen_n, waddr and wdata stable with no limit.
  - On an edge with mem_gnt=1: if row==N-1 go to FIN, else row+1 and go to LOAD.
  - wen_n=1 in every state except WRITE.
- FIN (1 cycle): done=1; go to IDLE.
- Quantization, per element p (20-bit unsigned):
  - s = min(shift_q, 19).
  - If s=0: q=p. Otherwise q = (p + 2^(s-1)) >> s, computed at 21 bits with no overflow.
  - Output byte = q if q ≤ 255, else 255; saturation sets sat_flag.
- sat_flag holds its value after done until the next accepted start.
- start while busy (including FIN) is ignored: no re-snapshot and no new clr_req.
- Latency with mem_gnt tied high:
  - Accepting edge is cycle 0; row r WRITE is at cycle 2r+2; done is at cycle 2N+1 (cycle 17 for N=8).
  - Each stall cycle adds one cycle.
- Reset mid-run: state returns to IDLE on the next edge; no further writes; no done pulse.

Test Plan:
- N=8, every psum=1000, shift=2, base=100, gnt=1 -> 8 writes to addresses 100..107, every byte 250; done exactly at cycle 17 after start; clr_req high at cycle 1 only; sat_flag=0.
- Rounding and saturation, shift=2: psum 5->1, 6->2, 1048575->255 with sat_flag=1. shift=0: 200->200, 300->255. shift=25: clamped to 19, psum 1048575 -> 2.
- Drop mem_gnt for 3 cycles during row 3 WRITE -> wen_n stays 0 and waddr/wdata stay stable across the stall; done moves to cycle 20.
- base=8190 -> addresses 8190, 8191, 0, 1, …, 5.
- Pulse start again at cycle 5 with different in_psum/base -> ignored; output data and addresses are from the first snapshot only; exactly one done.
- Assert rst during row 4 WRITE -> next cycle wen_n=1 and busy=0, no done; a fresh start afterwards completes normally.
